// File: rtl/alu_pkg.sv
// Shared op codes, FSM state type and helpers for the ALU arbiter.
package alu_pkg;

  localparam int unsigned OP_W = 4;

  localparam logic [OP_W-1:0] ALU_ADD = 4'b0000;
  localparam logic [OP_W-1:0] ALU_SUB = 4'b0001;
  localparam logic [OP_W-1:0] ALU_AND = 4'b0010;
  localparam logic [OP_W-1:0] ALU_OR  = 4'b0011;
  localparam logic [OP_W-1:0] ALU_XOR = 4'b0100;
  localparam logic [OP_W-1:0] ALU_SLT = 4'b0101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  // True for op codes with a defined ALU meaning; others pass through untouched.
  function automatic logic op_is_known(input logic [OP_W-1:0] op);
    return (op == ALU_ADD) || (op == ALU_SUB) || (op == ALU_AND) ||
           (op == ALU_OR)  || (op == ALU_XOR) || (op == ALU_SLT);
  endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to the one not granted last.
module rr_arbiter_2 (
  input  logic [1:0] valid_i,
  input  logic       last_grant_i,
  output logic [1:0] grant_o
);

  // One-hot or zero grant from current valids and the previous winner.
  always_comb begin
    grant_o    = 2'b00;
    grant_o[0] = valid_i[0] & (~valid_i[1] | last_grant_i);
    grant_o[1] = valid_i[1] & (~valid_i[0] | ~last_grant_i);
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters; one operation in flight,
// sequenced accept -> execute -> respond.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             r0_valid,
  output logic             r0_ready,
  input  logic [WIDTH-1:0] r0_a,
  input  logic [WIDTH-1:0] r0_b,
  input  logic [OP_W-1:0]  r0_op,
  output logic             r0_rsp_valid,
  input  logic             r0_rsp_ready,
  output logic [WIDTH-1:0] r0_result,
  output logic             r0_zero,
  input  logic             r1_valid,
  output logic             r1_ready,
  input  logic [WIDTH-1:0] r1_a,
  input  logic [WIDTH-1:0] r1_b,
  input  logic [OP_W-1:0]  r1_op,
  output logic             r1_rsp_valid,
  input  logic             r1_rsp_ready,
  output logic [WIDTH-1:0] r1_result,
  output logic             r1_zero,
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  output logic [OP_W-1:0]  alu_op,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zero
);

  arb_state_t       state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_grant_q, last_grant_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic [1:0]       grant;
  logic             accept_ok;
  logic             owner_rsp_ready;

  rr_arbiter_2 u_rr (
    .valid_i      ({r1_valid, r0_valid}),
    .last_grant_i (last_grant_q),
    .grant_o      (grant)
  );

  // Requests are only taken in IDLE, and never in a cycle that is being reset.
  assign accept_ok = (state_q == IDLE) && !rst;
  assign r0_ready  = accept_ok & grant[0];
  assign r1_ready  = accept_ok & grant[1];

  assign owner_rsp_ready = owner_q ? r1_rsp_ready : r0_rsp_ready;

  // Next-state and register updates for the accept/execute/respond sequence.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    result_d     = result_q;
    zero_d       = zero_q;
    unique case (state_q)
      IDLE: begin
        if (r0_ready) begin
          a_d     = r0_a;
          b_d     = r0_b;
          op_d    = r0_op;
          owner_d = 1'b0;
          state_d = EXEC;
        end else if (r1_ready) begin
          a_d     = r1_a;
          b_d     = r1_b;
          op_d    = r1_op;
          owner_d = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        result_d = alu_out;
        zero_d   = alu_zero;
        state_d  = RESP;
      end
      RESP: begin
        if (owner_rsp_ready) begin
          last_grant_d = owner_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= ALU_ADD;
      result_q     <= '0;
      zero_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      result_q     <= result_d;
      zero_q       <= zero_d;
    end
  end

  assign r0_rsp_valid = (state_q == RESP) && !owner_q;
  assign r1_rsp_valid = (state_q == RESP) &&  owner_q;
  assign r0_result    = result_q;
  assign r1_result    = result_q;
  assign r0_zero      = zero_q;
  assign r1_zero      = zero_q;
  assign alu_in1      = a_q;
  assign alu_in2      = b_q;
  assign alu_op       = op_q;

endmodule
